// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and helpers for the pipelined adder/subtractor.
//   n_stg()     - number of pipeline stages for a WIDTH/CHUNK split
//   smax/smin() - signed limits for a given width (returned in MAX_W bits)
//   flags_t     - registered result flags {cout, cmsb, overflow}
package addsub_pkg;

  // Widest operand the limit helpers support.
  localparam int unsigned MAX_W = 128;

  typedef struct packed {
    logic cout;
    logic cmsb;
    logic overflow;
  } flags_t;

  function automatic int unsigned n_stg(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Largest positive two's-complement value of the given width.
  function automatic logic [MAX_W-1:0] smax(input int unsigned width);
    return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
  endfunction

  // Most negative two's-complement value of the given width.
  function automatic logic [MAX_W-1:0] smin(input int unsigned width);
    return MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit adder slice.
//   a, b  - slice operands (b already inverted for subtract)
//   cin   - carry into the slice
//   s     - slice sum
//   cout  - carry out of the slice MSB
//   cmsb  - carry into the slice MSB
module addsub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] tot_c;

  assign tot_c = {1'b0, a} + {1'b0, b} + (CHUNK+1)'(cin);
  assign s     = tot_c[CHUNK-1:0];
  assign cout  = tot_c[CHUNK];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out by XOR.
  assign cmsb  = a[CHUNK-1] ^ b[CHUNK-1] ^ tot_c[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: valid/ready pipelined adder/subtractor, one CHUNK-bit
// slice per stage with the carry registered between stages.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid, in_ready   - operand handshake
//   sub, cin, a, b       - mode (1: a-b), add carry-in, operands
//   sat                  - clamp on signed overflow (PIPELINED_ADDSUB_SAT_EN only)
//   out_valid, out_ready - result handshake
//   sum, cout, cmsb, overflow - registered result and flags
// Optional feature macro: PIPELINED_ADDSUB_SAT_EN (adds the sat port).
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef PIPELINED_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             cmsb,
  output logic             overflow
);

  localparam int unsigned N_STG = n_stg(WIDTH, CHUNK);

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0 || WIDTH > MAX_W) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a nonzero multiple of CHUNK");
  end

  // Stage registers (_q) and the stage inputs feeding them (_d).
  logic             vld_q [N_STG];
  logic             vld_d [N_STG];
  logic [WIDTH-1:0] opa_q [N_STG];
  logic [WIDTH-1:0] opa_d [N_STG];
  logic [WIDTH-1:0] opb_q [N_STG];
  logic [WIDTH-1:0] opb_d [N_STG];
  logic [WIDTH-1:0] sum_q [N_STG];
  logic [WIDTH-1:0] sum_d [N_STG];
  logic [WIDTH-1:0] sum_nx [N_STG];
  logic             cy_q  [N_STG];
  logic             cin_d [N_STG];
  logic [CHUNK-1:0] s_c   [N_STG];
  logic             co_c  [N_STG];
  logic             cm_c  [N_STG];
  logic [WIDTH-1:0] sum_last_c;
  flags_t           flags_c;
  flags_t           flags_q;
  logic             stall_c;
`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));
  logic             sat_q [N_STG];
  logic             sat_d [N_STG];
`endif

  // Global stall: the whole pipe, bubbles included, freezes behind an unread result.
  assign stall_c  = out_valid & ~out_ready;
  assign in_ready = ~stall_c;

  for (genvar k = 0; k < N_STG; k++) begin : g_stg
    if (k == 0) begin : g_head
      // Subtract as a + ~b + 1; cin is ignored in that mode.
      assign vld_d[k] = in_valid;
      assign opa_d[k] = a;
      assign opb_d[k] = sub ? ~b : b;
      assign cin_d[k] = sub | cin;
      assign sum_d[k] = '0;
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign sat_d[k] = sat;
`endif
    end else begin : g_tail
      assign vld_d[k] = vld_q[k-1];
      assign opa_d[k] = opa_q[k-1];
      assign opb_d[k] = opb_q[k-1];
      assign cin_d[k] = cy_q[k-1];
      assign sum_d[k] = sum_q[k-1];
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign sat_d[k] = sat_q[k-1];
`endif
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (opa_d[k][k*CHUNK +: CHUNK]),
      .b    (opb_d[k][k*CHUNK +: CHUNK]),
      .cin  (cin_d[k]),
      .s    (s_c[k]),
      .cout (co_c[k]),
      .cmsb (cm_c[k])
    );

    // Lower slices arrive complete; upper bits are still zero, so OR merges slice k.
    assign sum_nx[k] = sum_d[k] | (WIDTH'(s_c[k]) << (k * CHUNK));
  end

  // Last stage: flags and (optionally) signed saturation of the result.
  assign flags_c = '{cout:     co_c[N_STG-1],
                     cmsb:     cm_c[N_STG-1],
                     overflow: co_c[N_STG-1] ^ cm_c[N_STG-1]};

`ifdef PIPELINED_ADDSUB_SAT_EN
  assign sum_last_c = (sat_d[N_STG-1] && flags_c.overflow)
                    ? (opa_d[N_STG-1][WIDTH-1] ? SMIN : SMAX)
                    : sum_nx[N_STG-1];
`else
  assign sum_last_c = sum_nx[N_STG-1];
`endif

  // Pipeline registers; all hold together on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_STG; k++) begin
        vld_q[k] <= 1'b0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
        cy_q[k]  <= 1'b0;
`ifdef PIPELINED_ADDSUB_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end
      flags_q <= '0;
    end else if (!stall_c) begin
      for (int k = 0; k < N_STG; k++) begin
        vld_q[k] <= vld_d[k];
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        cy_q[k]  <= co_c[k];
`ifdef PIPELINED_ADDSUB_SAT_EN
        sat_q[k] <= sat_d[k];
`endif
      end
      for (int k = 0; k < N_STG - 1; k++) begin
        sum_q[k] <= sum_nx[k];
      end
      sum_q[N_STG-1] <= sum_last_c;
      flags_q        <= flags_c;
    end
  end

  assign out_valid = vld_q[N_STG-1];
  assign sum       = sum_q[N_STG-1];
  assign cout      = flags_q.cout;
  assign cmsb      = flags_q.cmsb;
  assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed and randomized checks of pipelined_addsub
// (WIDTH=32, CHUNK=8) against a plain-arithmetic reference model.
module tb_pipelined_addsub;

  localparam int unsigned W     = 32;
  localparam int unsigned N_STG = 4;
`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  typedef struct packed {
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sat;
  } op_t;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         cm;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef PIPELINED_ADDSUB_SAT_EN
  logic         sat = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         cmsb;
  logic         overflow;

  res_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   run_len  = 0;
  int   max_run  = 0;

  pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .cin       (cin),
    .a         (a),
    .b         (b),
`ifdef PIPELINED_ADDSUB_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .cmsb      (cmsb),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: 64-bit integer arithmetic, signed range test for overflow.
  function automatic res_t model(input op_t op);
    longint unsigned ua, ub, ur;
    longint          sa, sb, sr;
    res_t            r;
    ua = 64'(op.a);
    ub = 64'(op.b);
    sa = longint'($signed(op.a));
    sb = longint'($signed(op.b));
    if (op.sub) begin
      ur   = ua - ub;
      r.co = (ua >= ub);
      sr   = sa - sb;
    end else begin
      ur   = ua + ub + 64'(op.cin);
      r.co = (ur >= 64'h1_0000_0000);
      sr   = sa + sb + longint'(op.cin);
    end
    r.s  = ur[31:0];
    r.ov = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
    r.cm = r.co ^ r.ov;
    if (op.sat && SAT_ON && r.ov) r.s = op.a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return r;
  endfunction

  function automatic op_t mk(input logic s, input logic c, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic st);
    op_t o;
    o.sub = s; o.cin = c; o.a = x; o.b = y; o.sat = st;
    return o;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return W'($urandom());
    endcase
  endfunction

  function automatic op_t rnd_op();
    return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs away from the edge, track the scoreboard.
  task automatic tick(input logic iv, input op_t op, input logic ordy, output logic seen);
    in_valid  = iv;
    sub       = op.sub;
    cin       = op.cin;
    a         = op.a;
    b         = op.b;
`ifdef PIPELINED_ADDSUB_SAT_EN
    sat       = op.sat;
`endif
    out_ready = ordy;
    #1;
    seen = out_valid;
    chk("in_ready", 32'(in_ready), 32'(!(out_valid && !ordy)));
    if (out_valid === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (expq.size() == 0) begin
        chk("stray_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("sum",      sum,            expq[0].s);
        chk("cout",     32'(cout),      32'(expq[0].co));
        chk("cmsb",     32'(cmsb),      32'(expq[0].cm));
        chk("overflow", 32'(overflow),  32'(expq[0].ov));
        if (ordy) void'(expq.pop_front());
      end
    end else begin
      run_len = 0;
    end
    if (iv && in_ready === 1'b1) expq.push_back(model(op));
    @(negedge clk);
  endtask

  task automatic drain();
    logic s;
    op_t  idle;
    idle = '0;
    for (int i = 0; i < 40 && expq.size() > 0; i++) tick(1'b0, idle, 1'b1, s);
    chk("drain_empty", 32'(expq.size()), 32'd0);
    repeat (N_STG) tick(1'b0, idle, 1'b1, s);
  endtask

  initial begin
    logic s;
    op_t  idle;
    int   first;
    idle = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_sum",       sum,            32'd0);
    chk("rst_flags",     32'({cout, cmsb, overflow}), 32'd0);

    // Latency: FFFFFFFF + 1 appears N_STG cycles after the accept cycle
    tick(1'b1, mk(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0), 1'b1, s);
    first = -1;
    for (int i = 1; i <= 6; i++) begin
      tick(1'b0, idle, 1'b1, s);
      if (s === 1'b1 && first < 0) first = i;
    end
    chk("latency", 32'(first), 32'(N_STG));

    // Directed boundary cases, issued back to back
    tick(1'b1, mk(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0), 1'b1, s);
    tick(1'b1, mk(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b1), 1'b1, s);
    tick(1'b1, mk(1'b1, 1'b0, 32'd5, 32'd7, 1'b0), 1'b1, s);
    tick(1'b1, mk(1'b1, 1'b1, 32'd7, 32'd5, 1'b0), 1'b1, s);
    tick(1'b1, mk(1'b0, 1'b1, 32'h0000_00FF, 32'h0000_FF00, 1'b0), 1'b1, s);
    tick(1'b1, mk(1'b1, 1'b0, 32'h8000_0000, 32'h1, 1'b1), 1'b1, s);
    tick(1'b1, mk(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1), 1'b1, s);
    drain();

    // Back-to-back stream of 8 -> 8 consecutive out_valid cycles
    run_len = 0;
    max_run = 0;
    repeat (8) tick(1'b1, rnd_op(), 1'b1, s);
    drain();
    chk("b2b_run", 32'(max_run), 32'd8);

    // Fill the pipe, then stall 3 cycles while still offering operands
    repeat (N_STG) tick(1'b1, rnd_op(), 1'b1, s);
    repeat (3) begin
      tick(1'b1, rnd_op(), 1'b0, s);
      chk("stall_out_valid", 32'(s), 32'd1);
    end
    drain();

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      tick(1'($urandom_range(0, 9) < 7), rnd_op(), 1'($urandom_range(0, 9) < 7), s);
    end
    drain();

    // Reset with 3 results in flight: nothing stale may surface
    repeat (3) tick(1'b1, rnd_op(), 1'b1, s);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_sum",       sum,            32'd0);
    repeat (8) tick(1'b0, idle, 1'b1, s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
